// File: rtl/conv_channel_feeder_if.sv
// Memory read port and ConvChannel stream/result signals of the feeder.
// master = feeder side, slave = RAM/ConvChannel side.
interface conv_channel_feeder_if #(
    parameter int DataWidth = 64,
    parameter int Channels  = 4,
    parameter int AddrWidth = 19
);
    localparam int StreamWidth = Channels * DataWidth;

    logic                   mem_rd;
    logic [AddrWidth-1:0]   mem_addr;
    logic [StreamWidth-1:0] mem_rdata;
    logic                   conv_rst;
    logic [8:0]             row_out;
    logic [8:0]             col_out;
    logic [StreamWidth-1:0] weight_out;
    logic                   weight_valid;
    logic [StreamWidth-1:0] data_out;
    logic                   data_valid;
    logic                   result_ready;

    modport master (
        output mem_rd, mem_addr, conv_rst, row_out, col_out,
               weight_out, weight_valid, data_out, data_valid,
        input  mem_rdata, result_ready
    );

    modport slave (
        input  mem_rd, mem_addr, conv_rst, row_out, col_out,
               weight_out, weight_valid, data_out, data_valid,
        output mem_rdata, result_ready
    );
endinterface

// File: rtl/conv_channel_feeder.sv
// ConvChannel transmit side: reset pulse, weight load, pixel load, result drain.
// Optional drain watchdog enabled by defining FEEDER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// RST     | conv_rst held high for 2 cycles
// WLOAD   | KernelSize weight reads
// GAP     | GapCycles cycles without reads
// DLOAD   | row*col pixel reads
// DRAIN   | waiting for all results
// DONE    | one-cycle done pulse
module conv_channel_feeder #(
    parameter int DataWidth     = 64,
    parameter int Channels      = 4,
    parameter int KernelSize    = 9,
    parameter int AddrWidth     = 19,
    parameter int GapCycles     = 4
`ifdef FEEDER_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 1024
`endif
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [8:0]  row_in,
    input  logic [8:0]  col_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [17:0] result_count,
    conv_channel_feeder_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WLOAD, S_GAP, S_DLOAD, S_DRAIN, S_DONE
    } state_t;

    state_t               state, state_d;
    logic [17:0]          cnt, cnt_d;
    logic [AddrWidth-1:0] addr;
    logic [8:0]           row_q, col_q;
    logic [17:0]          rcount;
    logic [17:0]          p;
    logic                 pwr_q, wv_q, dv_q, rd;

    assign p  = {9'd0, row_q} * {9'd0, col_q};
    assign rd = (state == S_WLOAD) || (state == S_DLOAD);

`ifdef FEEDER_TIMEOUT_EN
    // Reload to TimeoutCycles-2 so DONE is entered TimeoutCycles cycles after the last result.
    localparam int WdWidth = $clog2(TimeoutCycles);
    localparam logic [WdWidth-1:0] WdReload = WdWidth'(TimeoutCycles - 2);
    logic [WdWidth-1:0] wd;
    logic               wd_expire;
    logic               timeout_q;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
`ifdef FEEDER_TIMEOUT_EN
        wd_expire = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (row_in == 9'd0 || col_in == 9'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RST;
                        cnt_d   = 18'd1;
                    end
                end
            end
            S_RST: begin
                if (cnt == 18'd0) begin
                    state_d = S_WLOAD;
                    cnt_d   = 18'(KernelSize - 1);
                end else begin
                    cnt_d = cnt - 18'd1;
                end
            end
            S_WLOAD: begin
                if (cnt == 18'd0) begin
                    state_d = S_GAP;
                    cnt_d   = 18'(GapCycles - 1);
                end else begin
                    cnt_d = cnt - 18'd1;
                end
            end
            S_GAP: begin
                if (cnt == 18'd0) begin
                    state_d = S_DLOAD;
                    cnt_d   = p - 18'd1;
                end else begin
                    cnt_d = cnt - 18'd1;
                end
            end
            S_DLOAD: begin
                if (cnt == 18'd0) state_d = S_DRAIN;
                else              cnt_d   = cnt - 18'd1;
            end
            S_DRAIN: begin
                if (rcount == p) begin
                    state_d = S_DONE;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (wd == '0 && !bus.result_ready) begin
                    state_d   = S_DONE;
                    wd_expire = 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr   <= '0;
            row_q  <= '0;
            col_q  <= '0;
            rcount <= '0;
            pwr_q  <= 1'b1;
            wv_q   <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pwr_q <= 1'b0;
            wv_q  <= (state == S_WLOAD);
            dv_q  <= (state == S_DLOAD);
            if (rd) addr <= addr + 1'b1;
            if (state == S_IDLE && start) begin
                row_q  <= row_in;
                col_q  <= col_in;
                rcount <= '0;
                addr   <= '0;
            end else if ((state == S_DLOAD || state == S_DRAIN) &&
                         bus.result_ready && rcount != p) begin
                rcount <= rcount + 18'd1;
            end
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wd        <= WdReload;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) timeout_q <= 1'b0;
            else if (wd_expire)           timeout_q <= 1'b1;
            if (state != S_DRAIN || bus.result_ready) wd <= WdReload;
            else if (wd != '0)                        wd <= wd - 1'b1;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign result_count = rcount;

    assign bus.mem_rd       = rd;
    assign bus.mem_addr     = rd ? addr : '0;
    assign bus.conv_rst     = pwr_q || (state == S_RST);
    assign bus.row_out      = row_q;
    assign bus.col_out      = col_q;
    assign bus.weight_valid = wv_q;
    assign bus.data_valid   = dv_q;
    assign bus.weight_out   = wv_q ? bus.mem_rdata : '0;
    assign bus.data_out     = dv_q ? bus.mem_rdata : '0;
endmodule
